// File: rtl/m68k_bus_arbiter_if.sv
// Handshake and status bundle between the 68000 bus arbiter and its surroundings
// (external master pins, the bus-cycle engine, and status readback).
interface m68k_bus_arbiter_if;
  logic       M68K_BR_n;
  logic       M68K_BGACK_n;
  logic       cpu_req;
  logic       cpu_cycle_active;
  logic       sys_reset;
  logic       stat_clr;
  logic       M68K_BG_n;
  logic       cpu_grant;
  logic       bus_release;
  logic       ext_owner;
  logic       grant_timeout;
  logic       spurious_br;
  logic [7:0] ext_tenures;

  modport slave (
    input  M68K_BR_n, M68K_BGACK_n, cpu_req, cpu_cycle_active, sys_reset, stat_clr,
    output M68K_BG_n, cpu_grant, bus_release, ext_owner, grant_timeout, spurious_br,
           ext_tenures
  );

  modport master (
    output M68K_BR_n, M68K_BGACK_n, cpu_req, cpu_cycle_active, sys_reset, stat_clr,
    input  M68K_BG_n, cpu_grant, bus_release, ext_owner, grant_timeout, spurious_br,
           ext_tenures
  );
endinterface

// File: rtl/m68k_bus_arbiter.sv
// BR_n/BG_n/BGACK_n arbiter: hands the 68000 bus to external masters between
// engine cycles and gates when the PiStorm engine may start a new cycle.
module m68k_bus_arbiter #(
  parameter int unsigned RECLAIM_CYCLES = 4,
  parameter int unsigned GRANT_TIMEOUT  = 256,
  parameter int unsigned GUARD_CYCLES   = 2
) (
  input logic          PI_CLK,
  input logic          RESET_n,
  m68k_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT_IDLE, GRANT, EXT, RECLAIM} state_e;

  localparam logic [11:0] GuardLim   = 12'(GUARD_CYCLES);
  localparam logic [11:0] TimeoutLim = 12'(GRANT_TIMEOUT);
  localparam logic [11:0] ReclaimLim = 12'(RECLAIM_CYCLES);

  state_e      state_q, state_d;
  logic [1:0]  br_sync_q, bgack_sync_q;
  logic        br, bgack;
  logic [11:0] cnt_q, cnt_d, cnt_inc;
  logic        bg_n_q, cpu_grant_q, bus_release_q, ext_owner_q;
  logic        timeout_q, timeout_d, spurious_q, spurious_d;
  logic [7:0]  tenures_q, tenures_d;
  logic        set_timeout, set_spurious, tenure_done;

  // cpu_req only feeds the engine; a bus request always wins regardless of it.
  logic unused_cpu_req;
  assign unused_cpu_req = bus.cpu_req;

  assign br      = ~br_sync_q[1];
  assign bgack   = ~bgack_sync_q[1];
  assign cnt_inc = cnt_q + 12'd1;

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      br_sync_q    <= 2'b11;
      bgack_sync_q <= 2'b11;
    end else begin
      br_sync_q    <= {br_sync_q[0], bus.M68K_BR_n};
      bgack_sync_q <= {bgack_sync_q[0], bus.M68K_BGACK_n};
    end
  end

  // One shared counter: guard in WAIT_IDLE, timeout in GRANT, reclaim in RECLAIM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    set_timeout  = 1'b0;
    set_spurious = 1'b0;
    tenure_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!br) begin
          state_d = IDLE;
        end else if (!bus.cpu_cycle_active) begin
          if (cnt_inc == GuardLim) state_d = GRANT;
          else                     cnt_d   = cnt_inc;
        end
      end
      GRANT: begin
        if (bgack) begin
          state_d = EXT;
        end else if (!br) begin
          state_d      = RECLAIM;
          set_spurious = 1'b1;
        end else if (cnt_q == TimeoutLim) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d       = cnt_inc;
          set_timeout = (cnt_inc == TimeoutLim);
        end
      end
      EXT: begin
        if (!bgack) begin
          state_d     = RECLAIM;
          tenure_done = 1'b1;
        end
      end
      RECLAIM: begin
        if (cnt_inc == ReclaimLim) state_d = br ? WAIT_IDLE : IDLE;
        else                       cnt_d   = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
    if (bus.sys_reset) begin
      state_d      = IDLE;
      cnt_d        = '0;
      set_timeout  = 1'b0;
      set_spurious = 1'b0;
      tenure_done  = 1'b0;
    end
  end

  assign timeout_d  = (timeout_q & ~bus.stat_clr) | set_timeout;
  assign spurious_d = (spurious_q & ~bus.stat_clr) | set_spurious;
  assign tenures_d  = tenures_q + 8'(tenure_done);

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bg_n_q        <= 1'b1;
      cpu_grant_q   <= 1'b0;
      bus_release_q <= 1'b0;
      ext_owner_q   <= 1'b0;
      timeout_q     <= 1'b0;
      spurious_q    <= 1'b0;
      tenures_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bg_n_q        <= (state_d != GRANT);
      cpu_grant_q   <= (state_d == IDLE) && !bus.sys_reset;
      // Drivers stay released through the first reclaim cycle after an external tenure.
      bus_release_q <= (state_d == EXT) || ((state_d == RECLAIM) && (state_q == EXT));
      ext_owner_q   <= (state_d == EXT);
      timeout_q     <= timeout_d;
      spurious_q    <= spurious_d;
      tenures_q     <= tenures_d;
    end
  end

  assign bus.M68K_BG_n     = bg_n_q;
  assign bus.cpu_grant     = cpu_grant_q;
  assign bus.bus_release   = bus_release_q;
  assign bus.ext_owner     = ext_owner_q;
  assign bus.grant_timeout = timeout_q;
  assign bus.spurious_br   = spurious_q;
  assign bus.ext_tenures   = tenures_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Self-checking bench for m68k_bus_arbiter: directed protocol scenarios followed by
// randomized tenures checked against latency rules derived from the protocol timing.
module tb_m68k_bus_arbiter;

  localparam int GUARD = 2;
  localparam int RECL  = 4;
  localparam int TMO   = 16;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  m68k_bus_arbiter_if busIf ();

  m68k_bus_arbiter #(
    .RECLAIM_CYCLES(RECL),
    .GRANT_TIMEOUT (TMO),
    .GUARD_CYCLES  (GUARD)
  ) dut (
    .PI_CLK (clk),
    .RESET_n(rstN),
    .bus    (busIf)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic brN, input logic bgackN, input logic act,
                               input logic sysRst, input logic clr);
    busIf.M68K_BR_n        = brN;
    busIf.M68K_BGACK_n     = bgackN;
    busIf.cpu_cycle_active = act;
    busIf.sys_reset        = sysRst;
    busIf.stat_clr         = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Sample point sits 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goTo(input int c);
    while (cyc < c) tick();
  endtask

  task automatic newScenario();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    cyc = 0;
  endtask

  initial begin
    int         normalDone;
    logic [7:0] modelTen;

    busIf.cpu_req = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #12;
    $display("[TB] reset values");
    checkOutput("rst_bg_n", busIf.M68K_BG_n, 1);
    checkOutput("rst_cpu_grant", busIf.cpu_grant, 0);
    checkOutput("rst_bus_release", busIf.bus_release, 0);
    checkOutput("rst_ext_owner", busIf.ext_owner, 0);
    checkOutput("rst_timeout", busIf.grant_timeout, 0);
    checkOutput("rst_spurious", busIf.spurious_br, 0);
    checkOutput("rst_tenures", busIf.ext_tenures, 0);
    rstN = 1'b1;
    tick();
    checkOutput("grant_after_reset", busIf.cpu_grant, 1);

    $display("[TB] basic tenure");
    newScenario();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(2);  checkOutput("basic_grant_c2", busIf.cpu_grant, 1);
    goTo(3);  checkOutput("basic_grant_c3", busIf.cpu_grant, 0);
    goTo(4);  checkOutput("basic_bg_c4", busIf.M68K_BG_n, 1);
    goTo(5);  checkOutput("basic_bg_c5", busIf.M68K_BG_n, 0);
    goTo(10); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    goTo(11); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    goTo(12); checkOutput("basic_bg_c12", busIf.M68K_BG_n, 0);
              checkOutput("basic_owner_c12", busIf.ext_owner, 0);
    goTo(13); checkOutput("basic_bg_c13", busIf.M68K_BG_n, 1);
              checkOutput("basic_owner_c13", busIf.ext_owner, 1);
              checkOutput("basic_release_c13", busIf.bus_release, 1);
    goTo(40); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(42); checkOutput("basic_tenures_c42", busIf.ext_tenures, 0);
    goTo(43); checkOutput("basic_release_c43", busIf.bus_release, 1);
              checkOutput("basic_tenures_c43", busIf.ext_tenures, 1);
    goTo(44); checkOutput("basic_release_c44", busIf.bus_release, 0);
    goTo(46); checkOutput("basic_grant_c46", busIf.cpu_grant, 0);
    goTo(47); checkOutput("basic_grant_c47", busIf.cpu_grant, 1);

    $display("[TB] request during engine cycle");
    newScenario();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    goTo(5);  applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    goTo(7);  checkOutput("busy_grant_c7", busIf.cpu_grant, 1);
    goTo(8);  checkOutput("busy_grant_c8", busIf.cpu_grant, 0);
    goTo(31); applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
              checkOutput("busy_bg_c31", busIf.M68K_BG_n, 1);
    goTo(32); checkOutput("busy_bg_c32", busIf.M68K_BG_n, 1);
    goTo(33); checkOutput("busy_bg_c33", busIf.M68K_BG_n, 0);
    goTo(34); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    goTo(35); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    goTo(40); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(46); checkOutput("busy_grant_c46", busIf.cpu_grant, 0);
    goTo(47); checkOutput("busy_grant_c47", busIf.cpu_grant, 1);
              checkOutput("busy_tenures", busIf.ext_tenures, 2);

    $display("[TB] spurious request");
    newScenario();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(5);  checkOutput("spur_bg_c5", busIf.M68K_BG_n, 0);
    goTo(6);  applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(8);  checkOutput("spur_bg_c8", busIf.M68K_BG_n, 0);
              checkOutput("spur_flag_c8", busIf.spurious_br, 0);
    goTo(9);  checkOutput("spur_bg_c9", busIf.M68K_BG_n, 1);
              checkOutput("spur_flag_c9", busIf.spurious_br, 1);
    goTo(12); checkOutput("spur_grant_c12", busIf.cpu_grant, 0);
    goTo(13); checkOutput("spur_grant_c13", busIf.cpu_grant, 1);
    goTo(14); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    goTo(15); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
              checkOutput("spur_cleared", busIf.spurious_br, 0);

    $display("[TB] stat_clr coinciding with set");
    newScenario();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(6);  applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(8);  applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    goTo(9);  applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
              checkOutput("setwins_flag", busIf.spurious_br, 1);
    goTo(10); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    goTo(11); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
              checkOutput("setwins_cleared", busIf.spurious_br, 0);
    goTo(14);

    $display("[TB] grant timeout");
    newScenario();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(5);  checkOutput("tmo_bg_c5", busIf.M68K_BG_n, 0);
    goTo(20); checkOutput("tmo_flag_c20", busIf.grant_timeout, 0);
    goTo(21); checkOutput("tmo_flag_c21", busIf.grant_timeout, 1);
              checkOutput("tmo_bg_c21", busIf.M68K_BG_n, 0);
    goTo(30); checkOutput("tmo_bg_c30", busIf.M68K_BG_n, 0);
              applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    goTo(31); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    goTo(33); checkOutput("tmo_bg_c33", busIf.M68K_BG_n, 1);
              checkOutput("tmo_owner_c33", busIf.ext_owner, 1);
    goTo(40); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(47); checkOutput("tmo_grant_c47", busIf.cpu_grant, 1);
              checkOutput("tmo_tenures", busIf.ext_tenures, 3);
              checkOutput("tmo_flag_sticky", busIf.grant_timeout, 1);
    goTo(48); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    goTo(49); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
              checkOutput("tmo_cleared", busIf.grant_timeout, 0);

    $display("[TB] sys_reset during EXT");
    newScenario();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(10); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    goTo(11); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    goTo(13); checkOutput("sysrst_owner_c13", busIf.ext_owner, 1);
    goTo(20); applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    goTo(21); checkOutput("sysrst_bg", busIf.M68K_BG_n, 1);
              checkOutput("sysrst_release", busIf.bus_release, 0);
              checkOutput("sysrst_grant", busIf.cpu_grant, 0);
              checkOutput("sysrst_owner", busIf.ext_owner, 0);
    goTo(25); checkOutput("sysrst_grant_held", busIf.cpu_grant, 0);
              applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(26); checkOutput("sysrst_grant_back", busIf.cpu_grant, 1);
              checkOutput("sysrst_tenures", busIf.ext_tenures, 3);

    $display("[TB] async reset during GRANT");
    newScenario();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    goTo(7);  checkOutput("areset_bg_before", busIf.M68K_BG_n, 0);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("areset_bg_now", busIf.M68K_BG_n, 1);
    checkOutput("areset_grant", busIf.cpu_grant, 0);
    checkOutput("areset_tenures", busIf.ext_tenures, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #10;
    rstN = 1'b1;
    tick();
    checkOutput("areset_grant_after", busIf.cpu_grant, 1);

    $display("[TB] randomized tenures up to counter wrap");
    normalDone = 0;
    modelTen   = 8'd0;
    while (normalDone < 256) begin
      int         brAt, actEnd, t, g, a, r, cEnd;
      bit         spur;
      logic       brN, bgackN, act;
      logic [7:0] expTen;
      newScenario();
      brAt   = int'($urandom_range(0, 3));
      actEnd = int'($urandom_range(0, 8));
      t      = ((brAt + 3 > actEnd) ? brAt + 3 : actEnd) + GUARD;
      spur   = ($urandom_range(0, 3) == 0);
      g      = t + 1;
      a      = t + int'($urandom_range(1, 4));
      r      = a + int'($urandom_range(1, 10));
      cEnd   = spur ? g + 3 + RECL : r + 3 + RECL;
      for (int c = 0; c <= cEnd; c++) begin
        goTo(c);
        brN    = spur ? !(c >= brAt && c < g) : !(c >= brAt && c < a + 1);
        bgackN = !(!spur && c >= a && c < r);
        act    = (c < actEnd);
        applyStimulus(brN, bgackN, act, 1'b0, 1'b0);
        expTen = modelTen + 8'((!spur && c >= r + 3) ? 1 : 0);
        checkOutput("rnd_grant", busIf.cpu_grant, (c < brAt + 3) || (c >= cEnd));
        checkOutput("rnd_bg_n", busIf.M68K_BG_n, !(c >= t && c < (spur ? g + 3 : a + 3)));
        checkOutput("rnd_owner", busIf.ext_owner, !spur && c >= a + 3 && c < r + 3);
        checkOutput("rnd_release", busIf.bus_release, !spur && c >= a + 3 && c <= r + 3);
        checkOutput("rnd_tenures", busIf.ext_tenures, expTen);
        checkOutput("rnd_spurious", busIf.spurious_br, spur && c >= g + 3);
        checkOutput("rnd_bg_grant_excl", !(busIf.M68K_BG_n == 1'b0 && busIf.cpu_grant == 1'b1), 1);
      end
      checkOutput("rnd_timeout", busIf.grant_timeout, 0);
      if (spur) begin
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rnd_spur_cleared", busIf.spurious_br, 0);
      end else begin
        modelTen = modelTen + 8'd1;
        normalDone++;
      end
    end
    checkOutput("tenure_wrap", busIf.ext_tenures, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
